// File: rtl/osyrys64_pkg.sv
// Shared RV64I core definitions: load funct3 encodings, data-memory word type
// and the default data-memory depth.
package osyrys64_pkg;

    // Load funct3 encodings; 3'b111 is not a legal load.
    typedef enum logic [2:0] {
        F3_BYTE       = 3'b000,
        F3_HALFWORD   = 3'b001,
        F3_WORD       = 3'b010,
        F3_DOUBLE     = 3'b011,
        F3_BYTE_U     = 3'b100,
        F3_HALFWORD_U = 3'b101,
        F3_WORD_U     = 3'b110
    } load_f3_e;

    typedef logic [63:0] dmem_word_t;

    localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/data_memory_load_extender.sv
// Combinational load extraction: selects the addressed byte/half/word/double
// from a 64-bit memory word, aligns it to bit 0 and sign- or zero-extends it.
// Misaligned accesses and illegal funct3 return zero with fault_o set.
module load_extender
    import osyrys64_pkg::*;
(
    input  dmem_word_t  word_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  f3_i,
    output dmem_word_t  data_o,
    output logic        fault_o
);

    dmem_word_t shifted;

    // Shift the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        data_o  = '0;
        fault_o = 1'b0;
        case (f3_i)
            F3_BYTE:       data_o = {{56{shifted[7]}}, shifted[7:0]};
            F3_BYTE_U:     data_o = {56'd0, shifted[7:0]};
            F3_HALFWORD: begin
                if (offset_i[0]) fault_o = 1'b1;
                else             data_o  = {{48{shifted[15]}}, shifted[15:0]};
            end
            F3_HALFWORD_U: begin
                if (offset_i[0]) fault_o = 1'b1;
                else             data_o  = {48'd0, shifted[15:0]};
            end
            F3_WORD: begin
                if (offset_i[1:0] != 2'b00) fault_o = 1'b1;
                else                        data_o  = {{32{shifted[31]}}, shifted[31:0]};
            end
            F3_WORD_U: begin
                if (offset_i[1:0] != 2'b00) fault_o = 1'b1;
                else                        data_o  = {32'd0, shifted[31:0]};
            end
            F3_DOUBLE: begin
                if (offset_i != 3'b000) fault_o = 1'b1;
                else                    data_o  = word_i;
            end
            default:       fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-enabled 64-bit data memory for the RV64I core. Stores write selected
// byte lanes; loads return an aligned, extended result one cycle after the
// request (read-first on same-word store/load collisions).
module data_memory
  import osyrys64_pkg::*;
#(
  parameter int unsigned DEPTH     = DMEM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [63:0] addr,
  input  logic [7:0]  byte_enable,
  input  logic [63:0] write_data,
  input  logic [2:0]  f3,
  output logic [63:0] read_data,
  output logic        read_valid,
  output logic        load_fault
);

  if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_memory: DEPTH must be a power of two");
  end

  dmem_word_t mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;

  assign word_idx         = addr[ADDR_W+2:3];
  assign unused_addr_bits = ^addr[63:ADDR_W+3];

  // Byte-lane store; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (byte_enable[i]) begin
          mem[word_idx][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  dmem_word_t word_q;
  logic [2:0] off_q;
  logic [2:0] f3_q;

  // Synchronous raw read; the old contents are captured even if a store
  // to the same word lands at this edge.
  always_ff @(posedge clk) begin
    if (re) begin
      word_q <= mem[word_idx];
      off_q  <= addr[2:0];
      f3_q   <= f3;
    end
  end

  dmem_word_t ext_data;
  logic       ext_fault;

  load_extender u_load_extender (
    .word_i   (word_q),
    .offset_i (off_q),
    .f3_i     (f3_q),
    .data_o   (ext_data),
    .fault_o  (ext_fault)
  );

  logic       valid_q, valid_d;
  dmem_word_t hold_q, hold_d;

  // Next-state: a request launches a result; the last result is retained.
  always_comb begin
    valid_d = re;
    hold_d  = valid_q ? ext_data : hold_q;
  end

  // Result-valid flag and held output; reset discards pending loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign read_valid = valid_q;
  assign read_data  = valid_q ? ext_data : hold_q;
  assign load_fault = valid_q & ext_fault;

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory against a byte-array model.
module tb_data_memory;
    import osyrys64_pkg::*;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned NBYTES = DEPTH * 8;

    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [63:0] addr, write_data, read_data;
    logic [7:0]  byte_enable;
    logic [2:0]  f3;
    logic        read_valid, load_fault;

    always #5 clk = ~clk;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .re          (re),
        .addr        (addr),
        .byte_enable (byte_enable),
        .write_data  (write_data),
        .f3          (f3),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .load_fault  (load_fault)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [NBYTES];
    logic [63:0] last_data = '0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    bit          mon_en    = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, req, $time);
        end
    endtask

    // Reference load: little-endian byte gather with natural-alignment rule.
    function automatic exp_t model_load(logic [63:0] a, logic [2:0] f);
        exp_t        e;
        int unsigned size, base;
        logic [63:0] v;
        e.data  = '0;
        e.fault = 1'b0;
        size = 1 << f[1:0];
        if (f == 3'b111 || (a % size) != 0) begin
            e.fault = 1'b1;
            return e;
        end
        base = int'(a[ADDR_W+2:0]);
        v = '0;
        for (int k = 0; k < int'(size); k++) v |= 64'(mem_m[base + k]) << (8 * k);
        if (!f[2] && size < 8 && v[8*size-1]) v |= {64{1'b1}} << (8 * size);
        e.data = v;
        return e;
    endfunction

    // One clock of stimulus; expectation is computed before the store (read-first).
    task automatic op(bit w, bit r, logic [63:0] a, logic [7:0] be, logic [63:0] wd,
                      logic [2:0] f, bit rs);
        we = w; re = r; addr = a; byte_enable = be; write_data = wd; f3 = f; rst = rs;
        if (r && !rs) exp_q.push_back(model_load(a, f));
        @(posedge clk);
        #1;
        if (w && !rs) begin
            for (int i = 0; i < 8; i++)
                if (be[i]) mem_m[int'({a[ADDR_W+2:3], 3'(i)})] = wd[8*i +: 8];
        end
        if (rs) last_data = '0;
        we = 1'b0; re = 1'b0; rst = 1'b0;
    endtask

    // Monitor: pop an expectation whenever a result is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (read_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got read_valid=1, expected no result at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("load_data", read_data, e.data);
                        check("load_fault", 64'(load_fault), 64'(e.fault));
                        last_data = e.data;
                    end
                end else begin
                    check("idle_hold_data", read_data, last_data);
                    check("idle_fault", 64'(load_fault), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [63:0] a;
        int          kind;
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0;
        byte_enable = '0; write_data = '0; f3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(read_valid), 64'd0);
        check("reset_data", read_data, 64'd0);
        check("reset_fault", 64'(load_fault), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Prefill the test region (bytes 0..0x1FF).
        for (int w = 0; w < 64; w++)
            op(1, 0, 64'(w * 8), 8'hFF, {$urandom(), $urandom()}, 3'b000, 0);

        // Full store then LD, exactly one cycle latency.
        op(1, 0, 64'h40, 8'hFF, 64'h1122334455667788, 3'b000, 0);
        op(0, 1, 64'h40, 8'h00, 64'h0, F3_DOUBLE, 0);
        @(negedge clk);
        check("ld_latency_valid", 64'(read_valid), 64'd1);
        check("ld_latency_data", read_data, 64'h1122334455667788);

        // Single-byte store and byte/double reloads.
        op(1, 0, 64'h43, 8'h08, 64'hAB << 24, 3'b000, 0);
        op(0, 1, 64'h43, 8'h00, 64'h0, F3_BYTE_U, 0);
        op(0, 1, 64'h43, 8'h00, 64'h0, F3_BYTE, 0);
        op(0, 1, 64'h40, 8'h00, 64'h0, F3_DOUBLE, 0);
        @(negedge clk);
        check("sb_then_ld", read_data, 64'h11223344AB667788);

        // Word/half extension.
        op(1, 0, 64'h80, 8'hFF, 64'h80000000_FFFF8001, 3'b000, 0);
        op(0, 1, 64'h84, 8'h00, 64'h0, F3_WORD, 0);
        op(0, 1, 64'h84, 8'h00, 64'h0, F3_WORD_U, 0);
        op(0, 1, 64'h80, 8'h00, 64'h0, F3_HALFWORD, 0);
        @(negedge clk);
        check("lh_sign", read_data, 64'hFFFFFFFFFFFF8001);

        // Misaligned loads and illegal funct3.
        op(0, 1, 64'h81, 8'h00, 64'h0, F3_HALFWORD, 0);
        op(0, 1, 64'h84, 8'h00, 64'h0, F3_DOUBLE, 0);
        op(0, 1, 64'h80, 8'h00, 64'h0, 3'b111, 0);
        @(negedge clk);
        check("illegal_f3_fault", 64'(load_fault), 64'd1);

        // Same-cycle store and load to one word: read-first.
        op(1, 0, 64'h100, 8'hFF, 64'h5, 3'b000, 0);
        op(1, 1, 64'h100, 8'hFF, 64'hDEAD, F3_DOUBLE, 0);
        op(0, 1, 64'h100, 8'h00, 64'h0, F3_DOUBLE, 0);
        @(negedge clk);
        check("collision_after", read_data, 64'hDEAD);

        // Reset discards a coincident load and suppresses a coincident store.
        op(1, 0, 64'h1F8, 8'hFF, 64'hCAFEF00D_12345678, 3'b000, 0);
        op(0, 1, 64'h1F8, 8'h00, 64'h0, F3_DOUBLE, 1);
        op(1, 0, 64'h1F0, 8'hFF, 64'h0BAD0BAD_0BAD0BAD, 3'b000, 1);
        @(negedge clk);
        check("post_reset_valid", 64'(read_valid), 64'd0);
        check("post_reset_data", read_data, 64'd0);
        op(0, 1, 64'h1F8, 8'h00, 64'h0, F3_DOUBLE, 0);
        op(0, 1, 64'h1F0, 8'h00, 64'h0, F3_DOUBLE, 0);

        // Wrap: high address bits are ignored.
        op(0, 1, 64'hFFFF_0000_0000_2040, 8'h00, 64'h0, F3_DOUBLE, 0);

        // Randomised mix within the test region, with random upper bits.
        for (int n = 0; n < 500; n++) begin
            a = {$urandom(), $urandom()};
            a[ADDR_W+2:9] = '0;
            kind = int'($urandom_range(0, 3));
            op(kind == 0 || kind == 2, kind == 1 || kind == 2, a,
               8'($urandom()), {$urandom(), $urandom()}, 3'($urandom()),
               $urandom_range(0, 49) == 0);
        end

        repeat (4) op(0, 0, 64'h0, 8'h00, 64'h0, 3'b000, 0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
